// File: rtl/operand_fetch_stage.sv
// ---------------------------------------------------------------------------
// operand_fetch_stage
//   Decode-to-execute stage. Drives the register file read ports straight
//   from the decode slot. Resolves each source operand by forwarding from
//   MEM (ALU results only) or WB, or by using the register file read data.
//   Stalls decode on a load-use hazard and registers the resolved operands
//   into the ID/EX pipeline register. A saturating counter accumulates the
//   number of stall cycles.
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   valid_i, rs_i, rt_i,       decode slot: valid, source A/B indices,
//   dest_i, reg_write_i,       destination, write enable, load flag
//   mem_read_i, flush_i        and branch-redirect squash
//   Read_Register_1/2_o        register file read addresses
//   Read_Data_1/2_i            register file read data
//   exmem_*_i                  MEM-stage write enable, load flag, dest, data
//   wb_*_i                     WB-stage write enable, dest, data
//   stall_o                    combinational: hold decode inputs this cycle
//   valid_o, op_a_o, op_b_o,   ID/EX register contents
//   dest_o, reg_write_o,
//   mem_read_o
//   stall_count_o              saturating stall-cycle count
// ---------------------------------------------------------------------------
module operand_fetch_stage #(
    parameter int N      = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] rs_i,
    input  logic [ADDR_W-1:0] rt_i,
    input  logic [ADDR_W-1:0] dest_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] Read_Register_1_o,
    output logic [ADDR_W-1:0] Read_Register_2_o,
    input  logic [N-1:0]      Read_Data_1_i,
    input  logic [N-1:0]      Read_Data_2_i,
    input  logic              exmem_reg_write_i,
    input  logic              exmem_mem_read_i,
    input  logic [ADDR_W-1:0] exmem_dest_i,
    input  logic [N-1:0]      exmem_data_i,
    input  logic              wb_reg_write_i,
    input  logic [ADDR_W-1:0] wb_dest_i,
    input  logic [N-1:0]      wb_data_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [N-1:0]      op_a_o,
    output logic [N-1:0]      op_b_o,
    output logic [ADDR_W-1:0] dest_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic [CNT_W-1:0]  stall_count_o
);

    localparam logic [ADDR_W-1:0] REG_ZERO = {ADDR_W{1'b0}};
    localparam logic [N-1:0]      DATA_ZERO = {N{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ID/EX pipeline register and stall counter
    logic              valid_q,     valid_d;
    logic [N-1:0]      op_a_q,      op_a_d;
    logic [N-1:0]      op_b_q,      op_b_d;
    logic [ADDR_W-1:0] dest_q,      dest_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [N-1:0] op_a_s;
    logic [N-1:0] op_b_s;
    logic         haz_ex_s;
    logic         haz_mem_s;
    logic         stall_s;

    // A producer register x conflicts with the decode slot when it is a real
    // register (r0 is hard-wired) and is read by either source.
    function automatic logic src_match(
        input logic [ADDR_W-1:0] x,
        input logic [ADDR_W-1:0] rs,
        input logic [ADDR_W-1:0] rt
    );
        return (x != REG_ZERO) && ((x == rs) || (x == rt));
    endfunction

    // Operand resolution, nearest producer first. A MEM-stage load has no
    // data yet, so it is never a forwarding source. The WB match also covers
    // the register file write happening in this same cycle, whose read
    // still returns the old value.
    function automatic logic [N-1:0] resolve(
        input logic [ADDR_W-1:0] idx,
        input logic [N-1:0]      rf_data,
        input logic              ex_rw,
        input logic              ex_mr,
        input logic [ADDR_W-1:0] ex_dest,
        input logic [N-1:0]      ex_data,
        input logic              wb_rw,
        input logic [ADDR_W-1:0] wb_dest,
        input logic [N-1:0]      wb_data
    );
        logic [N-1:0] res;
        if (idx == REG_ZERO) begin
            res = DATA_ZERO;
        end else if (ex_rw && !ex_mr && (ex_dest == idx)) begin
            res = ex_data;
        end else if (wb_rw && (wb_dest == idx)) begin
            res = wb_data;
        end else begin
            res = rf_data;
        end
        return res;
    endfunction

    assign Read_Register_1_o = rs_i;
    assign Read_Register_2_o = rt_i;

    // Operand forwarding and load-use hazard detection
    always_comb begin
        op_a_s = resolve(rs_i, Read_Data_1_i, exmem_reg_write_i, exmem_mem_read_i,
                         exmem_dest_i, exmem_data_i, wb_reg_write_i, wb_dest_i, wb_data_i);
        op_b_s = resolve(rt_i, Read_Data_2_i, exmem_reg_write_i, exmem_mem_read_i,
                         exmem_dest_i, exmem_data_i, wb_reg_write_i, wb_dest_i, wb_data_i);
        // load one stage ahead (in ID/EX) or two stages ahead (in MEM)
        haz_ex_s  = valid_q && mem_read_q && reg_write_q && src_match(dest_q, rs_i, rt_i);
        haz_mem_s = exmem_mem_read_i && exmem_reg_write_i && src_match(exmem_dest_i, rs_i, rt_i);
        // a squashed slot never stalls
        stall_s   = valid_i && (haz_ex_s || haz_mem_s) && !flush_i;
    end

    assign stall_o = stall_s;

    // ID/EX next state: flush, stall and empty slot all inject a bubble
    always_comb begin
        valid_d     = 1'b0;
        op_a_d      = DATA_ZERO;
        op_b_d      = DATA_ZERO;
        dest_d      = REG_ZERO;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        if (flush_i || stall_s || !valid_i) begin
            valid_d     = 1'b0;
            op_a_d      = DATA_ZERO;
            op_b_d      = DATA_ZERO;
            dest_d      = REG_ZERO;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else begin
            valid_d     = 1'b1;
            op_a_d      = op_a_s;
            op_b_d      = op_b_s;
            dest_d      = dest_i;
            reg_write_d = reg_write_i;
            mem_read_d  = mem_read_i;
        end
    end

    // Stall counter next state: saturates, unaffected by flush
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // ID/EX register and stall counter state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            op_a_q      <= DATA_ZERO;
            op_b_q      <= DATA_ZERO;
            dest_q      <= REG_ZERO;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            valid_q     <= valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            dest_q      <= dest_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign valid_o       = valid_q;
    assign op_a_o        = op_a_q;
    assign op_b_o        = op_b_q;
    assign dest_o        = dest_q;
    assign reg_write_o   = reg_write_q;
    assign mem_read_o    = mem_read_q;
    assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch_stage
//   Directed scenarios followed by randomized traffic. A behavioural model
//   holds the expected ID/EX contents and stall count; every cycle the DUT
//   outputs are compared against it half a cycle after the rising edge.
//   A small stale register file array supplies Read_Data during random runs.
// ---------------------------------------------------------------------------
module tb_operand_fetch_stage;

    localparam int N      = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_i;
    logic [ADDR_W-1:0] rs_i, rt_i, dest_i;
    logic              reg_write_i, mem_read_i, flush_i;
    logic [ADDR_W-1:0] Read_Register_1_o, Read_Register_2_o;
    logic [N-1:0]      Read_Data_1_i, Read_Data_2_i;
    logic              exmem_reg_write_i, exmem_mem_read_i;
    logic [ADDR_W-1:0] exmem_dest_i;
    logic [N-1:0]      exmem_data_i;
    logic              wb_reg_write_i;
    logic [ADDR_W-1:0] wb_dest_i;
    logic [N-1:0]      wb_data_i;
    logic              stall_o, valid_o;
    logic [N-1:0]      op_a_o, op_b_o;
    logic [ADDR_W-1:0] dest_o;
    logic              reg_write_o, mem_read_o;
    logic [CNT_W-1:0]  stall_count_o;

    operand_fetch_stage #(.N(N), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .valid_i(valid_i), .rs_i(rs_i), .rt_i(rt_i), .dest_i(dest_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .flush_i(flush_i),
        .Read_Register_1_o(Read_Register_1_o), .Read_Register_2_o(Read_Register_2_o),
        .Read_Data_1_i(Read_Data_1_i), .Read_Data_2_i(Read_Data_2_i),
        .exmem_reg_write_i(exmem_reg_write_i), .exmem_mem_read_i(exmem_mem_read_i),
        .exmem_dest_i(exmem_dest_i), .exmem_data_i(exmem_data_i),
        .wb_reg_write_i(wb_reg_write_i), .wb_dest_i(wb_dest_i), .wb_data_i(wb_data_i),
        .stall_o(stall_o), .valid_o(valid_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
        .dest_o(dest_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
        .stall_count_o(stall_count_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // model state: expected ID/EX contents and counter
    logic        m_valid, m_rw, m_mr, m_stall;
    int          m_dest;
    logic [31:0] m_a, m_b;
    int          m_cnt;
    logic [31:0] rf [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // value an instruction must receive for source register idx
    function automatic logic [31:0] want_operand(input int idx, input logic [31:0] rfd);
        if (idx == 0) return 32'd0;
        if (exmem_reg_write_i && !exmem_mem_read_i && int'(exmem_dest_i) == idx) return exmem_data_i;
        if (wb_reg_write_i && int'(wb_dest_i) == idx) return wb_data_i;
        return rfd;
    endfunction

    function automatic logic reads(input int x);
        return (x != 0) && (x == int'(rs_i) || x == int'(rt_i));
    endfunction

    // one cycle: check outputs, advance the model across the rising edge
    task automatic step();
        logic        n_valid, n_rw, n_mr;
        int          n_dest;
        logic [31:0] n_a, n_b;
        #1;
        if (!reset) begin
            m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_dest = 0;
            m_a = 32'd0; m_b = 32'd0; m_cnt = 0;
        end
        m_stall = valid_i && !flush_i &&
                  ((m_valid && m_mr && m_rw && reads(m_dest)) ||
                   (exmem_mem_read_i && exmem_reg_write_i && reads(int'(exmem_dest_i))));
        chk("rd_reg1", Read_Register_1_o, rs_i);
        chk("rd_reg2", Read_Register_2_o, rt_i);
        chk("stall", stall_o, m_stall);
        chk("valid", valid_o, m_valid);
        chk("op_a", op_a_o, m_a);
        chk("op_b", op_b_o, m_b);
        chk("dest", dest_o, m_dest);
        chk("reg_write", reg_write_o, m_rw);
        chk("mem_read", mem_read_o, m_mr);
        chk("stall_count", stall_count_o, m_cnt);
        if (reset && valid_i && !flush_i && !m_stall) begin
            n_valid = 1'b1; n_rw = reg_write_i; n_mr = mem_read_i; n_dest = int'(dest_i);
            n_a = want_operand(int'(rs_i), Read_Data_1_i);
            n_b = want_operand(int'(rt_i), Read_Data_2_i);
        end else begin
            n_valid = 1'b0; n_rw = 1'b0; n_mr = 1'b0; n_dest = 0; n_a = 32'd0; n_b = 32'd0;
        end
        @(posedge clk);
        if (reset) begin
            m_valid = n_valid; m_rw = n_rw; m_mr = n_mr; m_dest = n_dest;
            m_a = n_a; m_b = n_b;
            if (m_stall && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (wb_reg_write_i && wb_dest_i != 5'd0) rf[wb_dest_i] = wb_data_i;
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        valid_i = 1'b0; rs_i = 5'd0; rt_i = 5'd0; dest_i = 5'd0;
        reg_write_i = 1'b0; mem_read_i = 1'b0; flush_i = 1'b0;
        Read_Data_1_i = 32'd0; Read_Data_2_i = 32'd0;
        exmem_reg_write_i = 1'b0; exmem_mem_read_i = 1'b0; exmem_dest_i = 5'd0; exmem_data_i = 32'd0;
        wb_reg_write_i = 1'b0; wb_dest_i = 5'd0; wb_data_i = 32'd0;
    endtask

    task automatic issue_load_r4();
        set_idle();
        valid_i = 1'b1; dest_i = 5'd4; reg_write_i = 1'b1; mem_read_i = 1'b1;
        rs_i = 5'd1; rt_i = 5'd1;
        step();
    endtask

    initial begin
        int cnt0;
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
        m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_dest = 0; m_a = 32'd0; m_b = 32'd0;
        m_cnt = 0; m_stall = 1'b0;

        // reset held with a valid instruction present
        set_idle();
        reset = 1'b0;
        valid_i = 1'b1; rs_i = 5'd1;
        @(negedge clk);
        repeat (3) step();
        chk("reset_count_lit", stall_count_o, 4'd0);
        chk("reset_valid_lit", valid_o, 1'b0);
        reset = 1'b1;
        valid_i = 1'b1; rs_i = 5'd1; rt_i = 5'd2; dest_i = 5'd3; reg_write_i = 1'b1;
        Read_Data_1_i = 32'd11; Read_Data_2_i = 32'd22;
        step();
        #1;
        chk("release_valid_lit", valid_o, 1'b1);
        chk("release_op_a_lit", op_a_o, 32'd11);

        // forwarding priority: MEM over WB over register file
        set_idle();
        valid_i = 1'b1; rs_i = 5'd2; Read_Data_1_i = 32'd3;
        wb_reg_write_i = 1'b1; wb_dest_i = 5'd2; wb_data_i = 32'd7;
        exmem_reg_write_i = 1'b1; exmem_dest_i = 5'd2; exmem_data_i = 32'd20;
        step();
        #1;
        chk("fwd_mem_lit", op_a_o, 32'd20);
        chk("model_fwd_mem_lit", m_a, 32'd20);
        exmem_reg_write_i = 1'b0;
        step();
        #1;
        chk("fwd_wb_lit", op_a_o, 32'd7);
        wb_reg_write_i = 1'b0;
        step();
        #1;
        chk("fwd_none_lit", op_a_o, 32'd3);

        // same-cycle write bypass and register 0
        set_idle();
        valid_i = 1'b1; rt_i = 5'd25; Read_Data_2_i = 32'd0;
        wb_reg_write_i = 1'b1; wb_dest_i = 5'd25; wb_data_i = 32'd6;
        step();
        #1;
        chk("bypass_lit", op_b_o, 32'd6);
        rt_i = 5'd0; wb_dest_i = 5'd0; Read_Data_2_i = 32'd9;
        step();
        #1;
        chk("r0_lit", op_b_o, 32'd0);
        chk("model_r0_lit", m_b, 32'd0);

        // load-use: two stalls, then WB forward
        issue_load_r4();
        cnt0 = m_cnt;
        set_idle();
        valid_i = 1'b1; rs_i = 5'd4; dest_i = 5'd6; reg_write_i = 1'b1;
        #1;
        chk("lu_stall1_lit", stall_o, 1'b1);
        step();
        #1;
        chk("lu_bubble1_lit", valid_o, 1'b0);
        exmem_reg_write_i = 1'b1; exmem_mem_read_i = 1'b1; exmem_dest_i = 5'd4;
        #1;
        chk("lu_stall2_lit", stall_o, 1'b1);
        step();
        exmem_reg_write_i = 1'b0; exmem_mem_read_i = 1'b0; exmem_dest_i = 5'd0;
        wb_reg_write_i = 1'b1; wb_dest_i = 5'd4; wb_data_i = 32'd78;
        #1;
        chk("lu_nostall_lit", stall_o, 1'b0);
        step();
        #1;
        chk("lu_op_a_lit", op_a_o, 32'd78);
        chk("lu_valid_lit", valid_o, 1'b1);
        chk("lu_count_lit", stall_count_o, 4'(cnt0 + 2));

        // flush while the hazard is present
        issue_load_r4();
        cnt0 = m_cnt;
        set_idle();
        valid_i = 1'b1; rs_i = 5'd4; flush_i = 1'b1;
        #1;
        chk("flush_nostall_lit", stall_o, 1'b0);
        step();
        #1;
        chk("flush_bubble_lit", valid_o, 1'b0);
        chk("flush_count_lit", stall_count_o, 4'(cnt0));

        // reset asserted mid-stall
        issue_load_r4();
        set_idle();
        valid_i = 1'b1; rs_i = 5'd4;
        exmem_reg_write_i = 1'b1; exmem_mem_read_i = 1'b1; exmem_dest_i = 5'd7;
        #1;
        chk("mid_stall_lit", stall_o, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_reset_stall_lit", stall_o, 1'b0);
        chk("mid_reset_valid_lit", valid_o, 1'b0);
        chk("mid_reset_count_lit", stall_count_o, 4'd0);
        step();
        reset = 1'b1;
        step();
        step();

        // saturation via a persistent MEM-stage load hazard
        set_idle();
        valid_i = 1'b1; rs_i = 5'd5;
        exmem_reg_write_i = 1'b1; exmem_mem_read_i = 1'b1; exmem_dest_i = 5'd5;
        repeat (20) step();
        #1;
        chk("sat_count_lit", stall_count_o, 4'd15);
        chk("model_sat_lit", m_cnt, 15);

        // randomized traffic; decode inputs held while the model expects a stall
        set_idle();
        step();
        for (int c = 0; c < 3000; c++) begin
            if (!m_stall) begin
                valid_i     = ($urandom_range(0, 3) != 0);
                rs_i        = 5'($urandom_range(0, 7));
                rt_i        = 5'($urandom_range(0, 7));
                dest_i      = 5'($urandom_range(0, 7));
                reg_write_i = $urandom_range(0, 3) != 0;
                mem_read_i  = $urandom_range(0, 2) == 0;
            end
            flush_i           = $urandom_range(0, 9) == 0;
            exmem_reg_write_i = $urandom_range(0, 1) == 1;
            exmem_mem_read_i  = $urandom_range(0, 3) == 0;
            exmem_dest_i      = 5'($urandom_range(0, 7));
            exmem_data_i      = $urandom;
            wb_reg_write_i    = $urandom_range(0, 1) == 1;
            wb_dest_i         = 5'($urandom_range(0, 7));
            wb_data_i         = $urandom;
            Read_Data_1_i     = rf[rs_i];
            Read_Data_2_i     = rf[rt_i];
            reset             = ($urandom_range(0, 149) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
